// File: rtl/ifft2d_frame_sched_pkg.sv
// Shared definitions for the 2D IFFT frame scheduler: FSM states, width helpers and 8x8 kernel defaults.
package ifft2d_frame_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } sched_state_t;

    localparam int DEF_ROWS      = 8;
    localparam int DEF_OUT_BEATS = 8;

    function automatic int sched_clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // An ID bus never collapses to zero bits, even with a single requester.
    function automatic int sched_id_width(input int nreq);
        return (nreq > 1) ? sched_clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/ifft2d_frame_sched_tag_fifo.sv
// Tag FIFO holding the requester ID of every frame in flight through the IFFT core.
// DEPTH must be a power of two; push when full and pop when empty are ignored.
module ifft_tag_fifo
    import ifft2d_frame_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = sched_clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // The extra pointer MSB tells a full FIFO apart from an empty one.
    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                        (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && !o_empty;
    assign o_pop_data = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[PTR_W-1:0]] <= i_push_data;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ifft2d_frame_sched.sv
// Frame scheduler for the 8x8 2D IFFT: round-robin tile grant, row reads, start pulse and output tagging.
// Define SCHED_PERF_CNT_EN to add the perf_frames / perf_stall saturating counters.
module ifft2d_frame_sched
    import ifft2d_frame_sched_pkg::*;
#(
    parameter int  NREQ      = 4,
    parameter int  ADDR_W    = 10,
    parameter int  ROWS      = DEF_ROWS,
    parameter int  OUT_BEATS = DEF_OUT_BEATS,
    parameter int  FRAME_GAP = 2,
    parameter int  MAX_OUTST = 4,
    localparam int ID_W      = sched_id_width(NREQ)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ADDR_W-1:0] req_base,
    output logic [NREQ-1:0]        req_ack,
    output logic                   mem_rd_en,
    output logic [ADDR_W-1:0]      mem_rd_addr,
    output logic                   ifft_invalid,
    input  logic                   ifft_outvalid,
    output logic                   out_valid,
    output logic [ID_W-1:0]        out_id,
    output logic                   out_last,
    output logic                   busy,
    output logic                   err_orphan
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]            perf_frames,
    output logic [31:0]            perf_stall
`endif
);

    localparam int ROW_W  = sched_clog2(ROWS + 1);
    localparam int GAP_W  = sched_clog2(FRAME_GAP + 2);
    localparam int BEAT_W = sched_clog2(OUT_BEATS + 1);

    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [GAP_W-1:0]  LAST_GAP  = GAP_W'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(OUT_BEATS);
    localparam logic [ID_W-1:0]   LAST_REQ  = ID_W'(NREQ - 1);
    localparam logic [ID_W:0]     NREQ_V    = (ID_W + 1)'(NREQ);

    sched_state_t      r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ADDR_W-1:0] r_base;
    logic [ROW_W-1:0]  r_row;
    logic [GAP_W-1:0]  r_gap;
    logic [NREQ-1:0]   r_ack;
    logic              r_invalid;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_addr;

    logic              r_out_valid;
    logic [ID_W-1:0]   r_out_id;
    logic              r_out_last;
    logic [BEAT_W-1:0] r_beat;
    logic              r_err;

    logic [NREQ-1:0]   w_rot;
    logic [ID_W-1:0]   w_offset;
    logic [ID_W:0]     w_sum;
    logic              w_grant_found;
    logic [ID_W-1:0]   w_grant_idx;
    logic [ADDR_W-1:0] w_grant_base;
    logic              w_can_grant;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [ID_W-1:0]   w_fifo_head;
    logic              w_pop_ok;

    // Rotate the requests so the RR pointer sits at bit 0, pick the first set bit, rotate back.
    always_comb begin
        w_rot         = NREQ'({req_valid, req_valid} >> r_rr_ptr);
        w_offset      = '0;
        w_grant_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_grant_found && w_rot[k]) begin
                w_grant_found = 1'b1;
                w_offset      = ID_W'(k);
            end
        end
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_offset};
        if (w_sum >= NREQ_V) begin
            w_sum = w_sum - NREQ_V;
        end
        w_grant_idx  = w_sum[ID_W-1:0];
        w_grant_base = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant_idx == ID_W'(k)) begin
                w_grant_base = req_base[k*ADDR_W +: ADDR_W];
            end
        end
    end

    assign w_can_grant = (r_state == ST_IDLE) && w_grant_found && !w_fifo_full;

    // A new burst may only start when idle or on the final beat of the current one.
    assign w_pop_ok = ifft_outvalid && !w_fifo_empty && (!r_out_valid || r_out_last);

    ifft_tag_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (ID_W)
    ) u_tag_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .i_push      (w_can_grant),
        .i_push_data (w_grant_idx),
        .i_pop       (w_pop_ok),
        .o_pop_data  (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // Outputs are registered, so the state seen during a row beat already names the next action.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= '0;
            r_base    <= '0;
            r_row     <= '0;
            r_gap     <= '0;
            r_ack     <= '0;
            r_invalid <= 1'b0;
            r_rd_en   <= 1'b0;
            r_addr    <= '0;
        end else begin
            r_ack     <= '0;
            r_invalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_rd_en <= 1'b0;
                    if (w_can_grant) begin
                        r_ack     <= NREQ'(1) << w_grant_idx;
                        r_invalid <= 1'b1;
                        r_rd_en   <= 1'b1;
                        r_addr    <= w_grant_base;
                        r_base    <= w_grant_base;
                        r_row     <= ROW_W'(1);
                        r_rr_ptr  <= (w_grant_idx == LAST_REQ) ? '0 : w_grant_idx + 1'b1;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_rd_en <= 1'b1;
                    r_addr  <= r_base + ADDR_W'(r_row);
                    r_row   <= r_row + 1'b1;
                    if (r_row == LAST_ROW) begin
                        r_gap   <= '0;
                        r_state <= (FRAME_GAP > 0) ? ST_GAP : ST_IDLE;
                    end
                end
                ST_GAP: begin
                    r_rd_en <= 1'b0;
                    if (r_gap == LAST_GAP) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: begin
                    r_rd_en <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
            r_out_last  <= 1'b0;
            r_beat      <= '0;
            r_err       <= 1'b0;
        end else begin
            if (ifft_outvalid && !w_pop_ok) begin
                r_err <= 1'b1;
            end
            if (w_pop_ok) begin
                r_out_valid <= 1'b1;
                r_out_id    <= w_fifo_head;
                r_beat      <= BEAT_W'(1);
                r_out_last  <= (OUT_BEATS == 1);
            end else if (r_out_valid) begin
                if (r_out_last) begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_beat      <= '0;
                end else begin
                    r_beat     <= r_beat + 1'b1;
                    r_out_last <= ((r_beat + 1'b1) == LAST_BEAT);
                end
            end
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] r_perf_frames;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_frames <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (w_can_grant && (r_perf_frames != '1)) begin
                r_perf_frames <= r_perf_frames + 32'd1;
            end
            if ((r_state == ST_IDLE) && (req_valid != '0) && w_fifo_full && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_frames = r_perf_frames;
    assign perf_stall  = r_perf_stall;
`endif

    assign req_ack      = r_ack;
    assign ifft_invalid = r_invalid;
    assign mem_rd_en    = r_rd_en;
    assign mem_rd_addr  = r_addr;
    assign out_valid    = r_out_valid;
    assign out_id       = r_out_id;
    assign out_last     = r_out_last;
    assign err_orphan   = r_err;
    assign busy         = (r_state != ST_IDLE) || !w_fifo_empty || r_out_valid;

endmodule
